// File: rtl/adc_cfg_shifter.sv
// Configuration frame table and MSB-first serializer for the ADC serial port.
// Frame capture and shifting are paced by the sequencer's LOAD/SHEN/SCKEN strobes.
module adc_cfg_shifter #(
    parameter int WORD_W    = 48,
    parameter int NUM_WORDS = 17
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [4:0]        ADR,
    input  logic              LOAD,
    input  logic              SHEN,
    input  logic              SCKEN,
    input  logic              DONE,
    input  logic              WR_EN,
    input  logic [4:0]        WR_ADDR,
    input  logic [WORD_W-1:0] WR_DATA,
    output logic              WR_ACK,
    output logic              SDATA,
    output logic              SCLK_EN,
    output logic              CSB,
    output logic [4:0]        FRAMES,
    output logic              ADR_ERR,
    output logic              CONFIGURED,
    output logic              BUSY
);

    logic [WORD_W-1:0] r_table [NUM_WORDS];
    logic [WORD_W-1:0] r_sreg;
    logic              r_sclk_en;
    logic              r_csb;
    logic [4:0]        r_frames;
    logic              r_adr_err;
    logic              r_configured;
    logic              r_done_q;
    logic              r_wr_ack;

    logic              w_adr_ok;
    logic              w_wr_addr_ok;
    logic              w_busy;
    logic              w_wr_ok;
    logic              w_seq_start;
    logic              w_done_rise;
    logic [WORD_W-1:0] w_load_word;

    assign w_adr_ok     = (int'(ADR) < NUM_WORDS);
    assign w_wr_addr_ok = (int'(WR_ADDR) < NUM_WORDS);
    assign w_busy       = SCKEN | r_sclk_en;
    assign w_wr_ok      = WR_EN & ~w_busy & w_wr_addr_ok;
    // r_sclk_en is last cycle's SCKEN: a LOAD after an idle serial clock opens a new sequence.
    assign w_seq_start  = LOAD & ~r_sclk_en;
    assign w_done_rise  = DONE & ~r_done_q;

    always_comb begin
        w_load_word = '0;
        if (w_adr_ok) begin
            w_load_word = r_table[ADR];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_table[WR_ADDR] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ack <= 1'b0;
        end else begin
            r_wr_ack <= w_wr_ok;
        end
    end

    // LOAD wins over SHEN so a new frame never loses its MSB.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sreg <= '0;
        end else if (LOAD) begin
            r_sreg <= w_load_word;
        end else if (SHEN) begin
            r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sclk_en <= 1'b0;
            r_csb     <= 1'b1;
            r_done_q  <= 1'b0;
        end else begin
            r_sclk_en <= SCKEN;
            r_csb     <= ~(SHEN & ~LOAD);
            r_done_q  <= DONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_frames <= '0;
        end else if (w_seq_start) begin
            r_frames <= 5'd1;
        end else if (LOAD && (r_frames != 5'd31)) begin
            r_frames <= r_frames + 5'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_adr_err <= 1'b0;
        end else if (w_seq_start) begin
            r_adr_err <= ~w_adr_ok;
        end else if (LOAD && !w_adr_ok) begin
            r_adr_err <= 1'b1;
        end
    end

    // The error flag checked here is the one accumulated before this cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_configured <= 1'b0;
        end else if (w_seq_start) begin
            r_configured <= 1'b0;
        end else if (w_done_rise && !r_adr_err) begin
            r_configured <= 1'b1;
        end
    end

    assign WR_ACK     = r_wr_ack;
    assign SDATA      = r_sreg[WORD_W-1];
    assign SCLK_EN    = r_sclk_en;
    assign CSB        = r_csb;
    assign FRAMES     = r_frames;
    assign ADR_ERR    = r_adr_err;
    assign CONFIGURED = r_configured;
    assign BUSY       = w_busy;

endmodule

// File: tb/tb_adc_cfg_shifter.sv
// Bench for adc_cfg_shifter: per-cycle expected outputs from a frame/bit-index model,
// queued by the driver and compared by an independent monitor.
module tb_adc_cfg_shifter;
  localparam int W = 48;
  localparam int N = 17;

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [4:0]   ADR = '0;
  logic         LOAD = 0, SHEN = 0, SCKEN = 0, DONE = 0, WR_EN = 0;
  logic [4:0]   WR_ADDR = '0;
  logic [W-1:0] WR_DATA = '0;
  logic         WR_ACK, SDATA, SCLK_EN, CSB, ADR_ERR, CONFIGURED, BUSY;
  logic [4:0]   FRAMES;

  adc_cfg_shifter #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .CLK(CLK), .RST(RST), .ADR(ADR), .LOAD(LOAD), .SHEN(SHEN), .SCKEN(SCKEN),
    .DONE(DONE), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_ACK(WR_ACK), .SDATA(SDATA), .SCLK_EN(SCLK_EN), .CSB(CSB), .FRAMES(FRAMES),
    .ADR_ERR(ADR_ERR), .CONFIGURED(CONFIGURED), .BUSY(BUSY)
  );

  // scoreboard: {wr_ack, sdata, sclk_en, csb, frames[4:0], adr_err, configured, busy}
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // reference model: the captured frame plus how many bits of it have been sent
  logic [W-1:0] m_table [N];
  logic [W-1:0] m_frame;
  int           m_idx;
  int           m_frames;
  logic         m_sclk_en, m_csb, m_adr_err, m_cfg, m_done_q, m_wr_ack;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_table[i] = '0;
    m_frame = '0; m_idx = 0; m_frames = 0;
    m_sclk_en = 0; m_csb = 1; m_adr_err = 0; m_cfg = 0; m_done_q = 0; m_wr_ack = 0;
  endfunction

  function automatic logic [11:0] model_out(input logic scken);
    logic sd;
    sd = (m_idx < W) ? m_frame[W-1-m_idx] : 1'b0;
    return {m_wr_ack, sd, m_sclk_en, m_csb, 5'(m_frames), m_adr_err, m_cfg, scken | m_sclk_en};
  endfunction

  function automatic void model_update(input logic load, input logic [4:0] adr, input logic shen,
                                       input logic scken, input logic done, input logic wr_en,
                                       input logic [4:0] wr_addr, input logic [W-1:0] wr_data);
    logic         busy_now, start, in_rng, rise, old_err;
    logic [W-1:0] word;
    busy_now = scken | m_sclk_en;
    start    = load & ~m_sclk_en;
    in_rng   = (int'(adr) < N);
    rise     = done & ~m_done_q;
    old_err  = m_adr_err;
    word     = '0;
    if (in_rng) word = m_table[adr];
    m_wr_ack = wr_en && !busy_now && (int'(wr_addr) < N);
    if (m_wr_ack) m_table[wr_addr] = wr_data;
    if (load) begin
      m_frame = word;
      m_idx   = 0;
      if (start) begin
        m_frames = 1; m_adr_err = !in_rng; m_cfg = 0;
      end else begin
        if (m_frames < 31) m_frames++;
        if (!in_rng) m_adr_err = 1;
      end
    end else if (shen) begin
      m_idx++;
    end
    if (!start && rise && !old_err) m_cfg = 1;
    m_csb = !(shen && !load);
    m_sclk_en = scken;
    m_done_q = done;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: one expected vector per cycle, compared mid-cycle
  initial begin
    logic [11:0] e, a;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {WR_ACK, SDATA, SCLK_EN, CSB, FRAMES, ADR_ERR, CONFIGURED, BUSY};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL outputs @%0t: got %h expected %h (wack sdata sclken csb frames adrerr cfg busy)",
                   $time, a, e);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input logic load = 0, input logic [4:0] adr = 0, input logic shen = 0,
                      input logic scken = 0, input logic done = 0, input logic wr_en = 0,
                      input logic [4:0] wr_addr = 0, input logic [W-1:0] wr_data = 0);
    @(posedge CLK); #1;
    LOAD = load; ADR = adr; SHEN = shen; SCKEN = scken; DONE = done;
    WR_EN = wr_en; WR_ADDR = wr_addr; WR_DATA = wr_data;
    exp_q.push_back(model_out(scken));
    model_update(load, adr, shen, scken, done, wr_en, wr_addr, wr_data);
  endtask

  task automatic write_word(input logic [4:0] a, input logic [W-1:0] d);
    step(0, 0, 0, 0, 0, 1, a, d);
  endtask

  task automatic frame(input logic [4:0] a, input int nshift);
    step(1, a, 0, 1);
    for (int i = 0; i < nshift; i++) step(0, 0, 1, 1);
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1;
    LOAD = 0; SHEN = 0; SCKEN = 0; DONE = 0; WR_EN = 0; ADR = 0; WR_ADDR = 0; WR_DATA = '0;
    RST = 1;
    #1;
    chk("rst_csb", 48'(CSB), 48'd1);
    chk("rst_sdata", 48'(SDATA), 48'd0);
    chk("rst_frames", 48'(FRAMES), 48'd0);
    chk("rst_flags", 48'({SCLK_EN, ADR_ERR, CONFIGURED, BUSY, WR_ACK}), 48'd0);
    model_reset();
    exp_q.push_back(model_out(0));
    repeat (2) begin
      @(posedge CLK); #1;
      exp_q.push_back(model_out(0));
    end
    @(posedge CLK); #1;
    RST = 0;
    exp_q.push_back(model_out(0));
    model_update(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge CLK);
    apply_reset();

    // single frame, MSB first
    write_word(0, 48'hA5_0000_0000_01);
    step();
    frame(0, 47);
    step(); step();

    // full sequence of 17 frames then DONE
    for (int a = 1; a < N; a++) write_word(5'(a), {$urandom, 16'($urandom)});
    for (int a = 0; a < N; a++) frame(5'(a), 47);
    step(); step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1); step(); step();

    // out-of-range load then DONE must not configure
    frame(5'd20, 5);
    step(); step(0, 0, 0, 0, 1); step(); step();

    // write while busy is dropped; out-of-range write is dropped
    write_word(3, 48'h1234_5678_9ABC);
    step();
    step(0, 0, 0, 1, 0, 1, 3, 48'hFFFF_FFFF_FFFF);
    step(); step();
    write_word(20, 48'hDEAD_BEEF_0000);
    step();
    frame(3, 47);
    step(); step();

    // reset ten cycles into a frame, then the cleared table shifts zeros
    write_word(0, 48'hFFFF_0000_1234);
    step();
    frame(0, 9);
    apply_reset();
    frame(0, 47);
    step(); step();

    // same-cycle LOAD and SHEN
    write_word(1, 48'h0F0F_0F0F_0F0F);
    write_word(2, 48'h8000_0000_0001);
    step();
    frame(1, 6);
    step(1, 2, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
    step(); step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) == 0, 5'($urandom_range(0, 20)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           5'($urandom_range(0, 20)), {$urandom, 16'($urandom)});
    end
    step(); step();

    repeat (3) @(posedge CLK);
    chk("queue_drained", 48'(exp_q.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_cfg_shifter.md
# adc_cfg_shifter

Serializer stage directly downstream of the ADC configuration sequencer. Holds a writable table of configuration frames, captures the frame at the sequencer's address on each LOAD, and shifts it MSB-first to the ADC serial port as SDATA/SCLK_EN/CSB under the sequencer's SHEN/SCKEN strobes. Also reports progress and status (frames sent, address error, configured) to the slow-control register file.

## Interface
- WORD_W, 48: bits per configuration frame.
- NUM_WORDS, 17: number of table entries; valid addresses are 0..NUM_WORDS-1.
- CLK  in  1  system clock; all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- ADR  in  5  table address from the sequencer; sampled only when LOAD=1.
- LOAD  in  1  capture table[ADR] into the shift register.
- SHEN  in  1  shift enable; advances the shift register by one bit per cycle.
- SCKEN  in  1  serial clock enable from the sequencer.
- DONE  in  1  sequencer completion level.
- WR_EN  in  1  table write strobe.
- WR_ADDR  in  5  table write address.
- WR_DATA  in  WORD_W  table write data.
- WR_ACK  out  1  one-cycle pulse when a write is accepted.
- SDATA  out  1  serial data, MSB first.
- SCLK_EN  out  1  registered SCKEN; drives the external ODDR that forms SCLK.
- CSB  out  1  ADC chip select, active low.
- FRAMES  out  5  count of LOAD events since the last sequence start.
- ADR_ERR  out  1  sticky; set when LOAD arrives with ADR >= NUM_WORDS.
- CONFIGURED  out  1  set on the DONE rising edge if ADR_ERR=0.
- BUSY  out  1  high while SCKEN=1 or SCLK_EN=1.

## Operation
- Table: NUM_WORDS x WORD_W registers, all cleared to 0 on reset.
  - A write with WR_EN=1, BUSY=0 and WR_ADDR<NUM_WORDS updates the entry and pulses WR_ACK on the next cycle.
  - Any other write is dropped and does not pulse WR_ACK.
- Shift register sreg[WORD_W-1:0]; SDATA = sreg[WORD_W-1].
  - LOAD=1: sreg <= table[ADR] (or 0 if ADR is out of range). LOAD takes priority over SHEN in the same cycle.
  - SHEN=1, LOAD=0: sreg <= {sreg[WORD_W-2:0], 1'b0}.
  - Otherwise sreg holds.
- CSB <= ~(SHEN & ~LOAD), registered. CSB is therefore high in the cycle after each LOAD (frame delimiter) and high whenever SHEN=0.
- SCLK_EN <= SCKEN, registered, so it is cycle-aligned with SDATA and CSB.
- FRAMES:
  - Cleared on a LOAD that occurs while the previous-cycle SCKEN=0 (sequence start), then set to 1 by that same LOAD.
  - Incremented on every other LOAD; saturates at 31.
- ADR_ERR: set by an out-of-range LOAD; cleared at sequence start.
- CONFIGURED: set on a DONE 0->1 edge when ADR_ERR=0; cleared at sequence start.
- There is no FSM of its own. Sequencing comes from LOAD/SHEN/SCKEN; internal state is sreg, counters, sticky flags and DONE edge detect (DONE_q).

## Timing
- Reset values: SDATA=0, SCLK_EN=0, CSB=1, FRAMES=0, ADR_ERR=0, CONFIGURED=0, BUSY=0, WR_ACK=0, sreg=0, table=0.
- Latency: a LOAD in cycle n puts table[ADR][WORD_W-1] on SDATA in cycle n+1. Each SHEN cycle exposes the next bit one cycle later.
- SCLK_EN and CSB lag SCKEN/SHEN by exactly 1 cycle.
- CONFIGURED rises 1 cycle after the DONE rising edge.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The table is also cleared, so software must rewrite it.
- A WR_EN arriving during a frame is dropped: no WR_ACK, table unchanged.
- LOAD and SHEN together: load wins, no shift occurs in that cycle.

## Test plan
- Write table[0]=48'hA5_0000_0000_01 while idle, then LOAD with ADR=0, then 47 SHEN cycles -> WR_ACK pulses once. SDATA sequence is 1,0,1,0,0,1,0,1,... ending in 1 as the 48th bit. CSB is high 1 cycle after LOAD, then low.
- Full sequence: LOADs at ADR 0..16 with 48-cycle spacing, then DONE=1 -> FRAMES=17. ADR_ERR=0. CONFIGURED=1 one cycle after the DONE edge.
- LOAD with ADR=5'd20 -> sreg loads 0, SDATA=0, ADR_ERR=1. A later DONE does not set CONFIGURED.
- WR_EN with SCKEN=1 writing 48'hFFFF_FFFF_FFFF to entry 3, then read back via LOAD ADR=3 after idle -> no WR_ACK; SDATA shows the old value.
- RST pulsed 10 cycles into a frame -> CSB=1, SDATA=0 and FRAMES=0 in the same cycle. A LOAD of entry 0 afterwards shifts out all zeros.
- Same-cycle LOAD+SHEN -> no shift; the new word's MSB appears on SDATA the next cycle.
